// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter: buffers producer bytes and paces frames on tx_done.
// Optional sticky overflow flag is compiled in with `define UART_TX_FIFO_OVF_EN.
//
// state | meaning
// IDLE  | no frame in flight; pop as soon as the FIFO holds data
// BUSY  | frame handed to transmitter; waiting for its tx_done

module uart_tx_fifo #(
    parameter int DATA_BIT = 8,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [8:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     send_en,
    output logic [8:0]               data_in,
    input  logic                     tx_done,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_BIT-1:0]        mem_q [DEPTH];
    logic [DATA_BIT-1:0]        mem_d [DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       full_q, full_d;
    logic                       empty_q, empty_d;
    logic                       send_en_q, send_en_d;
    logic [8:0]                 data_in_q, data_in_d;
    logic                       overflow_q, overflow_d;
    logic                       wr_ok;
    logic                       pop;
    logic                       done_valid;
    logic                       unused_in;

    assign unused_in = ^{wr_data, ovf_clr};

    // A tx_done coinciding with our own send_en belongs to the previous frame.
    assign done_valid = tx_done && !send_en_q;
    assign wr_ok      = wr_en && !full_q;
    assign pop        = !empty_q && ((state_q == ST_IDLE) || done_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pop) state_d = ST_BUSY;
            ST_BUSY: if (done_valid && empty_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data[DATA_BIT-1:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        send_en_d = pop;
        data_in_d = data_in_q;
        if (pop) begin
            data_in_d                 = '0;
            data_in_d[DATA_BIT-1:0]   = mem_q[rd_ptr_q];
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (wr_en && full_q) overflow_d = 1'b1;
    end
`else
    always_comb begin
        overflow_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            send_en_q  <= 1'b0;
            data_in_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            send_en_q  <= send_en_d;
            data_in_q  <= data_in_d;
            overflow_q <= overflow_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign send_en  = send_en_q;
    assign data_in  = data_in_q;
    assign overflow = overflow_q;

endmodule
